// File: rtl/lsl_seq.sv
// Sequential shift-left-logical unit: shifts inA left by inB[AMT_W-1:0],
// one bit per clock, under a start/done handshake with a zero flag.
module lsl_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lslout,
    output logic             flag
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] cnt;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_inb;
    assign unused_inb = ^inB[WIDTH-1:AMT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lslout <= '0;
            flag   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= inA;
                        cnt   <= inB[AMT_W-1:0];
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The cnt==0 cycle publishes the result, so n shifts take n+1 cycles.
                    if (cnt != '0) begin
                        acc <= {acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt - AMT_W'(1);
                    end else begin
                        lslout <= acc;
                        flag   <= (acc == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsl_seq.sv
// Self-checking bench for lsl_seq: directed corner cases plus randomized
// operations checked against an arithmetic (multiply by 2^n) reference.
module tb_lsl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic        done;
    logic [31:0] lslout;
    logic        flag;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prevLsl;
    logic        prevFlag;
    logic [31:0] expRes;
    int          expN;

    always #5 clk = ~clk;

    lsl_seq #(.WIDTH(32), .AMT_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .inA    (inA),
        .inB    (inB),
        .busy   (busy),
        .done   (done),
        .lslout (lslout),
        .flag   (flag)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge (E0).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        expN   = int'(b % 32);
        prod   = {32'd0, a} * (64'd1 << expN);
        expRes = prod[31:0];
        start  = 1'b1;
        inA    = a;
        inB    = b;
        @(negedge clk);
        start  = 1'b0;
        inA    = $urandom;
        inB    = $urandom;
    endtask

    task automatic waitDone(input string tag, input bit pokeMid);
        int cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " holdRes"}, lslout, prevLsl);
            checkOutput({tag, " holdFlag"}, {31'd0, flag}, {31'd0, prevFlag});
            start = pokeMid && (cycles == 3);
            inA   = start ? 32'hFFFF_FFFF : $urandom;
            inB   = start ? 32'd1 : $urandom;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expN + 1));
        checkOutput({tag, " result"}, lslout, expRes);
        checkOutput({tag, " flag"}, {31'd0, flag}, {31'd0, expRes == 32'd0});
        checkOutput({tag, " busyAtDone"}, {31'd0, busy}, 32'd0);
        prevLsl  = expRes;
        prevFlag = (expRes == 32'd0);
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        checkOutput({tag, " donePulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idleBusy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " idleRes"}, lslout, prevLsl);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst lslout", lslout, 32'd0);
        checkOutput("rst flag", {31'd0, flag}, 32'd1);
        rst_n    = 1'b1;
        prevLsl  = 32'd0;
        prevFlag = 1'b1;
        @(negedge clk);

        applyStimulus(32'h0000_0001, 32'd4);            waitDone("basic", 1'b0);   idleCycle("basic");
        applyStimulus(32'hDEAD_BEEF, 32'd0);            waitDone("zeroAmt", 1'b0); idleCycle("zeroAmt");
        applyStimulus(32'h8000_0000, 32'd1);            waitDone("msbOut", 1'b0);  idleCycle("msbOut");
        applyStimulus(32'h0000_0001, 32'd31);           waitDone("max", 1'b0);     idleCycle("max");
        applyStimulus(32'h0000_00FF, 32'hFFFF_FFE3);    waitDone("mask", 1'b0);    idleCycle("mask");

        // Mid-operation start is ignored; start in the done cycle is accepted.
        applyStimulus(32'h0000_0001, 32'd8);            waitDone("busyIgn", 1'b1);
        applyStimulus(32'h0000_0003, 32'd2);            waitDone("b2b", 1'b0);     idleCycle("b2b");

        applyStimulus(32'h0000_1234, 32'd10);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRst busy", {31'd0, busy}, 32'd0);
        checkOutput("midRst done", {31'd0, done}, 32'd0);
        checkOutput("midRst lslout", lslout, 32'd0);
        checkOutput("midRst flag", {31'd0, flag}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midRst noDone", {31'd0, done}, 32'd0);
        end
        rst_n    = 1'b1;
        prevLsl  = 32'd0;
        prevFlag = 1'b1;
        @(negedge clk);
        checkOutput("postRst noDone", {31'd0, done}, 32'd0);
        applyStimulus(32'h0000_0005, 32'd1);            waitDone("postRst", 1'b0); idleCycle("postRst");

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) a = a & 32'h0000_000F;
            applyStimulus(a, b);
            waitDone("rand", 1'b0);
            if (i % 3 != 0) idleCycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsl_seq.md
# lsl_seq

Sequential shift-left-logical unit for the ALU datapath, the left-direction counterpart of the existing combinational right-shift-logical unit. It shifts a WIDTH-bit operand left by the low AMT_W bits of a second operand, one bit position per clock, under a start/done handshake. It produces the same result/zero-flag pair as the other ALU shift units. It sits beside them behind the ALU operation mux and trades latency for area: one 1-bit shifter instead of a barrel shifter.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- AMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- inA  input  WIDTH  value to shift; sampled with start.
- inB  input  WIDTH  shift amount; only inB[AMT_W-1:0] is used, upper bits are ignored; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; lslout and flag are valid from this cycle onward.
- lslout  output  WIDTH  result, inA << inB[AMT_W-1:0], zero-filled from the LSB.
- flag  output  1  zero flag: 1 when lslout == 0.

## Operation
- State machine with two states: IDLE and SHIFT.
- Internal registers:
  - acc: WIDTH-bit shift register.
  - cnt: AMT_W-bit down-counter.
- IDLE:
  - If start=1 on a clock edge: acc <= inA, cnt <= inB[AMT_W-1:0], move to SHIFT.
  - If start=0, hold.
- SHIFT with cnt != 0: acc <= {acc[WIDTH-2:0], 1'b0}, cnt <= cnt - 1, stay in SHIFT.
- SHIFT with cnt == 0:
  - lslout <= acc; flag <= (acc == 0); done <= 1; move to IDLE.
- done is a registered pulse, high for exactly one cycle per operation.
- busy is high in SHIFT and low in IDLE.
- start while busy=1 is ignored: it is not queued and does not disturb the operation in flight.
- Input operands are captured at start. Changes on inA/inB during SHIFT have no effect.
- lslout and flag hold their last result until the next done. They do not change during SHIFT.
- Bits shifted past the MSB are discarded. No carry or overflow output.
- A shift amount of 0 is legal: result = inA.
- The maximum amount is WIDTH-1 (31); bit 0 of inA then lands in bit 31.

## Timing
- Reset, asynchronous on rst_n=0:
  - State = IDLE; busy=0, done=0, lslout=0, flag=1.
  - acc and cnt are cleared to 0.
  - Deassertion is assumed synchronous to clk upstream.
- Reset asserted mid-operation aborts it immediately. No done pulse is produced, and outputs take their reset values.
- Latency: with shift amount n = inB[AMT_W-1:0] and start sampled at edge E0:
  - busy is high for cycles E0..E(n+1).
  - done is high in the cycle after edge E(n+1).
  - Total: n+1 cycles to result; min 1 (n=0), max 32 (n=31).
- Back-to-back: done coincides with IDLE, so start asserted in the done cycle is accepted. Throughput is one operation per n+2 cycles, with no dead cycle beyond that.
- A start held high continuously launches a new operation on every IDLE edge.

## Test plan
- Basic shift: inA=0x0000_0001, inB=4, start for 1 cycle -> busy high for 5 cycles, then done with lslout=0x0000_0010, flag=0.
- Zero amount: inA=0xDEAD_BEEF, inB=0 -> done 1 cycle after the start edge, lslout=0xDEAD_BEEF, flag=0.
- Bits shifted out:
  - inA=0x8000_0000, inB=1 -> lslout=0x0000_0000, flag=1.
  - inA=0x0000_0001, inB=31 -> lslout=0x8000_0000 after 32 cycles.
- Amount masking: inA=0x0000_00FF, inB=0xFFFF_FFE3 -> shift by 3, lslout=0x0000_07F8.
- Busy protection and back-to-back:
  - Start with inA=0x1, inB=8. Pulse start with inA=0xFFFF_FFFF, inB=1 mid-operation -> ignored; result 0x0000_0100.
  - Start asserted in the done cycle with inA=0x3, inB=2 -> accepted; next done gives 0x0000_000C.
- Reset mid-operation: rst_n=0 during the cycle-3 shift of an inB=10 operation -> busy=0, done=0, lslout=0, flag=1 immediately, and no done pulse. After release, a new start with inA=0x5, inB=1 -> lslout=0xA.
